// File: rtl/ttl_74166_sync_pkg.sv
// ttl_74166_sync_pkg
//   Shared constants for the synchronous 74166 shift register emulation.
//   The register width is the only constant. It is kept here so that
//   wrappers which cascade several shifters agree on the default width.
package ttl_74166_sync_pkg;

  // Default number of stages (A..H). Legal widths are 2 to 32.
  localparam int TTL74166_DEFAULT_BLOCKS = 8;

endpackage

// File: rtl/ttl_cen_rise.sv
// ttl_cen_rise
//   Detects a rising edge on the emulated TTL clock pin Cen, sampled on Clk.
//   The last-value register powers up high, so a Cen that is already high
//   at power-up does not produce a spurious event on the first cycle.
//   The register tracks Cen on every cycle and is never cleared. A clear on
//   the parent therefore still consumes an edge that coincides with it.
// Ports:
//   Clk       in   system clock
//   Cen       in   emulated TTL clock pin
//   cen_rise  out  high for the single Clk cycle in which Cen is first seen high
module ttl_cen_rise (
  input  logic Clk,
  input  logic Cen,
  output logic cen_rise
);

  logic last_cen_reg = 1'b1;

  always_ff @(posedge Clk) begin
    last_cen_reg <= Cen;
  end

  assign cen_rise = Cen & ~last_cen_reg;

endmodule

// File: rtl/ttl_74166_sync.sv
// ttl_74166_sync
//   Synchronous emulation of a 74166 parallel-in/serial-out shift register
//   with clear and clock inhibit. Each detected rising edge of Cen either
//   loads D (Sh_Ld_n low) or shifts one place toward H (Sh_Ld_n high).
//   Clk_inh set high blocks that event. Clr_n low zeroes the stages and
//   takes priority over load, shift and inhibit.
// Ports:
//   Clk      in   system clock
//   Clr_n    in   clear, active-low, synchronous
//   Cen      in   emulated TTL CLK pin, acts on its rising edge
//   Clk_inh  in   clock inhibit, active-high
//   Sh_Ld_n  in   1 = shift, 0 = parallel load
//   Ser      in   serial input into stage A (bit 0)
//   D        in   parallel data, D[0] = A ... D[BLOCKS-1] = H
//   Q        out  stage contents, for debug or cascade tap
//   Qh       out  serial output, last stage
module ttl_74166_sync
  import ttl_74166_sync_pkg::*;
#(
  parameter int BLOCKS = TTL74166_DEFAULT_BLOCKS
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              Cen,
  input  logic              Clk_inh,
  input  logic              Sh_Ld_n,
  input  logic              Ser,
  input  logic [BLOCKS-1:0] D,
  output logic [BLOCKS-1:0] Q,
  output logic              Qh
);

  logic [BLOCKS-1:0] q_reg = '0;
  logic [BLOCKS-1:0] shift_next;
  logic              cen_rise;

  ttl_cen_rise u_cen_rise (
    .Clk      (Clk),
    .Cen      (Cen),
    .cen_rise (cen_rise)
  );

  // Shifted value: Ser enters stage A, and each stage takes its lower
  // neighbour. The old H stage falls off the end.
  assign shift_next[0] = Ser;
  for (genvar gi = 1; gi < BLOCKS; gi++) begin : g_shift
    assign shift_next[gi] = q_reg[gi-1];
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      q_reg <= '0;
    end else if (cen_rise && !Clk_inh) begin
      q_reg <= Sh_Ld_n ? shift_next : D;
    end
  end

  assign Q  = q_reg;
  assign Qh = q_reg[BLOCKS-1];

endmodule

// File: doc/ttl_74166_sync.md
Name: ttl_74166_sync

Overview:
- Synchronous emulation of a 74166 8-bit parallel-in/serial-out shift register with clear and clock inhibit. It is the transmit side of the latch path.
- In the video datapath, a ttl_74174_sync-style latch captures tile/plane bytes, and this block loads those bytes and shifts pixels out serially.
- Everything runs on the single system clock Clk. The TTL clock pin is emulated by rising-edge detection of Cen, identical to the ttl_sync family.

Parameters:
- BLOCKS, 8, register width (number of stages A..H); legal range 2..32.

Ports:
- Clk  input  1  system clock; all state updates on posedge Clk.
- Clr_n  input  1  reset/clear; synchronous, active-low (pseudo-asynchronous clear of the TTL part).
- Cen  input  1  emulated TTL CLK pin; a shift/load event occurs on its detected rising edge.
- Clk_inh  input  1  clock inhibit, active-high; blocks shift/load events.
- Sh_Ld_n  input  1  high = shift, low = parallel load (load is synchronous to the Cen edge).
- Ser  input  1  serial input into stage A (bit 0).
- D  input  BLOCKS  parallel data; D[0] = A ... D[BLOCKS-1] = H.
- Q  output  BLOCKS  internal stage contents (debug/cascade tap).
- Qh  output  1  serial output = Q[BLOCKS-1].

Behaviour:
- State:
  - Q_reg[BLOCKS-1:0] power-up value 0.
  - last_cen power-up value 1, so no spurious edge on the first cycle.
- Edge detect: cen_rise = Cen && !last_cen, evaluated each Clk. last_cen <= Cen every cycle unconditionally, including while Clr_n is low.
- Priority per posedge Clk, highest first:
  1. Clr_n == 0 -> Q_reg <= 0. Overrides load, shift and inhibit.
  2. cen_rise && !Clk_inh && !Sh_Ld_n -> Q_reg <= D.
  3. cen_rise && !Clk_inh && Sh_Ld_n -> Q_reg <= {Q_reg[BLOCKS-2:0], Ser}; the H stage is discarded.
  4. Otherwise hold.
- Latency: Q/Qh change one Clk after the cycle in which Cen is first sampled high. Outputs are registered; no combinational path from any input to Q/Qh.
- Reset values: Q = 0, Qh = 0.
- Cen held high for several cycles produces exactly one event. Cen low->high on consecutive cycles (1 Clk low pulse) produces one event per rising edge.
- Clk_inh is sampled in the same cycle as cen_rise. If Clk_inh is high then, the edge is lost; deasserting Clk_inh while Cen stays high does NOT generate a late event.
- Sh_Ld_n, D and Ser are sampled only in the cen_rise cycle; changes between edges have no effect.
- Clear mid-shift:
  - Contents are zeroed.
  - A Cen rise in the same cycle as Clr_n low is consumed (last_cen still updates), so no event occurs after release until the next rising Cen.
- Cascade: Qh of stage n feeds Ser of stage n+1 with both driven by the same Cen. Each shift moves exactly one bit across, because Q is registered.
- After BLOCKS shifts with Ser = 0 following a load, Q == 0.

Decomposition:
- No package is needed; BLOCKS is the only shared constant.
- One natural sub-module: ttl_cen_rise, the Cen rising-edge detector with last_cen power-up at 1. It is reusable across ttl_*_sync counters and shifters.

Test Plan:
- Power-up, no reset, Cen held 1 for 5 Clk -> Q = 0x00, no event fired.
- Clr_n = 1, Sh_Ld_n = 0, D = 0xA5, one Cen rise -> Q = 0xA5, Qh = 1 one Clk later. Then Sh_Ld_n = 1, Ser = 0, 8 Cen rises -> Qh sequence 1,0,1,0,0,1,0,1, then Q = 0x00.
- Load 0x81, Cen held high 10 Clk -> Q stays 0x81, single event only. Cen pulse low for exactly 1 Clk between highs -> exactly one shift per rise.
- Clk_inh = 1 during a Cen rise with Sh_Ld_n = 0, D = 0xFF -> Q unchanged. Drop Clk_inh while Cen high -> still unchanged. Next rise -> Q = 0xFF.
- Q = 0x3C, Clr_n = 0 coincident with a Cen rise and load of D = 0xFF -> Q = 0x00. Release Clr_n with Cen still high -> Q stays 0x00 until the next rise.
- Two instances cascaded (Qh0 -> Ser1): load 0xF0 / 0x00, 8 shifts with Ser0 = 0 -> instance 1 Q = 0xF0, instance 0 Q = 0x00. Repeat with BLOCKS = 4 and a 0xA nibble for parameter coverage.
